// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryptor: one shared round datapath reused for 10 rounds,
// with the round key expanded on the fly from the previous round key.

// One AES S-box lookup; the table is packed MSB-first so entry 0 sits at [2047:2040].
module aes128Sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  // ~a * 8 is the bit offset of entry a counted from the LSB end
  assign y = TBL[{~a, 3'b000} +: 8];
endmodule

module aes128_iter_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} stateT;

  stateT          state, stateNext;
  logic [127:0]   st, rk, rkNext, roundOut, srFlat, mcFlat;
  logic [3:0]     rnd;
  logic [7:0]     rcon;
  logic           rndLegal;
  logic [15:0][7:0] sbB, srB, mcB;
  logic [31:0]    subRot, w0n, w1n, w2n, w3n;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes + ShiftRows; byte i is row i%4, column i/4, row r rotates left by r
  for (genvar i = 0; i < 16; i++) begin : gByte
    aes128Sbox uSbox (.a(st[127-8*i -: 8]), .y(sbB[i]));
    assign srB[i] = sbB[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
    assign srFlat[127-8*i -: 8] = srB[i];
    assign mcFlat[127-8*i -: 8] = mcB[i];
  end

  // MixColumns over each column of the shifted state
  for (genvar c = 0; c < 4; c++) begin : gMix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = srB[4*c];
    assign a1 = srB[4*c+1];
    assign a2 = srB[4*c+2];
    assign a3 = srB[4*c+3];
    assign mcB[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mcB[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mcB[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mcB[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  // SubWord(RotWord(w3)): output byte k comes from w3 byte (k+3)%4
  for (genvar k = 0; k < 4; k++) begin : gKey
    aes128Sbox uSbox (.a(rk[8*((k+3)%4) +: 8]), .y(subRot[8*k +: 8]));
  end

  // Round constant for the round currently being computed
  always_comb begin
    rcon = 8'h00;
    case (rnd)
      4'd1:  rcon = 8'h01;
      4'd2:  rcon = 8'h02;
      4'd3:  rcon = 8'h04;
      4'd4:  rcon = 8'h08;
      4'd5:  rcon = 8'h10;
      4'd6:  rcon = 8'h20;
      4'd7:  rcon = 8'h40;
      4'd8:  rcon = 8'h80;
      4'd9:  rcon = 8'h1b;
      4'd10: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign w0n      = rk[127:96] ^ subRot ^ {rcon, 24'h0};
  assign w1n      = rk[95:64] ^ w0n;
  assign w2n      = rk[63:32] ^ w1n;
  assign w3n      = rk[31:0]  ^ w2n;
  assign rkNext   = {w0n, w1n, w2n, w3n};
  assign roundOut = ((rnd == 4'd10) ? srFlat : mcFlat) ^ rkNext;
  assign rndLegal = (rnd != 4'd0) && (rnd <= 4'd10);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic; a corrupted round counter aborts back to IDLE
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (in_valid) stateNext = ROUND;
      ROUND:   if (!rndLegal) stateNext = IDLE;
               else if (rnd == 4'd10) stateNext = DONE;
      DONE:    if (out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: load round 0 on accept, one round per cycle, hold through DONE.
  // rnd wraps to 0 after round 10 so it never leaves 0..10.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st  <= '0;
      rk  <= '0;
      rnd <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          st  <= in_data ^ in_key;
          rk  <= in_key;
          rnd <= 4'd1;
        end
        ROUND: if (rndLegal) begin
          st  <= roundOut;
          rk  <= rkNext;
          rnd <= (rnd == 4'd10) ? 4'd0 : rnd + 4'd1;
        end else begin
          rnd <= 4'd0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = st;
endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Bench for aes128_iter_ctrl: known-answer vectors plus randomized blocks checked
// against a byte-array AES model whose S-box is derived from GF(2^8) arithmetic.
module tb_aes128_iter_ctrl;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data, in_key, out_data;
  int nTests = 0;
  int nFail  = 0;
  logic [7:0] sbT [256];

  aes128_iter_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] coef(input int d);
    case (d)
      0: return 8'h02;
      1: return 8'h03;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference AES-128: full key schedule up front, then 10 rounds on a byte array
  function automatic logic [127:0] aesRef(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc, acc;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbT[tmp[31:24]], sbT[tmp[23:16]], sbT[tmp[15:8]], sbT[tmp[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbT[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) s[q+4*c] = t[q+4*((c+q)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++)
          for (int q = 0; q < 4; q++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef((k - q + 4) % 4), s[k+4*c]);
            t[q+4*c] = acc;
          end
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Offer one block, scramble the inputs after acceptance, wait for out_valid
  task automatic runBlock(input logic [127:0] pt, input logic [127:0] key,
                          output logic [127:0] res, output int lat, output bit to);
    int w;
    w = 0;
    to = 1'b0;
    while (!in_ready && w < 30) begin @(posedge clk); #1; w++; end
    in_valid = 1'b1; in_data = pt; in_key = key;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = rnd128(); in_key = rnd128();
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    res = out_data;
    to = !out_valid;
  endtask

  task automatic releaseOut();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = rnd128(); in_key = rnd128(); out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nTests++; if (in_ready !== 1'b0) begin nFail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    nTests++; if (out_valid !== 1'b0) begin nFail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    nTests++; if (busy !== 1'b0) begin nFail++; $display("FAIL reset_busy: got %b want 0", busy); end
    nTests++; if (out_data !== 128'h0) begin nFail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    nTests++; if (in_ready !== 1'b1) begin nFail++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_fips_c1();
    logic [127:0] res; int lat; bit to;
    runBlock(C1_PT, C1_KEY, res, lat, to);
    nTests++; if (to) begin nFail++; $display("FAIL c1_timeout: out_valid not seen within %0d cycles", lat); end
    nTests++; if (lat !== 10) begin nFail++; $display("FAIL c1_latency: got %0d want 10", lat); end
    nTests++; if (res !== C1_CT) begin nFail++; $display("FAIL c1_data: got %h want %h", res, C1_CT); end
    nTests++; if (busy !== 1'b1 || in_ready !== 1'b0) begin nFail++; $display("FAIL c1_done_flags: busy %b in_ready %b want 1 0", busy, in_ready); end
    releaseOut();
    nTests++; if (out_valid !== 1'b0) begin nFail++; $display("FAIL c1_release: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_app_b();
    logic [127:0] res; int lat; bit to;
    runBlock(B_PT, B_KEY, res, lat, to);
    nTests++; if (res !== B_CT || to) begin nFail++; $display("FAIL appb_data: got %h want %h", res, B_CT); end
    nTests++; if (dut.rk !== B_RK10) begin nFail++; $display("FAIL appb_rk10: got %h want %h", dut.rk, B_RK10); end
    releaseOut();
  endtask

  task automatic test_backpressure();
    logic [127:0] pt, key, exp, res; int lat; bit to;
    pt = rnd128(); key = rnd128(); exp = aesRef(pt, key);
    runBlock(pt, key, res, lat, to);
    nTests++; if (res !== exp || to) begin nFail++; $display("FAIL bp_data: got %h want %h", res, exp); end
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom % 2); in_data = rnd128(); in_key = rnd128();
      @(posedge clk); #1;
      nTests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp) begin
        nFail++;
        $display("FAIL bp_hold cycle %0d: out_valid %b in_ready %b data %h want 1 0 %h", i, out_valid, in_ready, out_data, exp);
      end
    end
    // in_valid high on the releasing cycle must not be taken in DONE
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    nTests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      nFail++;
      $display("FAIL bp_release: out_valid %b in_ready %b busy %b want 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] outs [2];
    int accCyc [2];
    int nAcc, nOut, cyc;
    bit willAcc, willOut;
    nAcc = 0; nOut = 0; cyc = 0;
    outs[0] = '0; outs[1] = '0; accCyc[0] = 0; accCyc[1] = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = '0; in_key = '0;
    for (int i = 0; i < 60 && nOut < 2; i++) begin
      willAcc = in_valid && in_ready;
      willOut = out_valid && out_ready;
      if (willOut) outs[nOut] = out_data;
      @(posedge clk); #1;
      cyc++;
      if (willAcc) begin
        if (nAcc < 2) accCyc[nAcc] = cyc;
        nAcc++;
        if (nAcc == 1) begin in_data = C1_PT; in_key = C1_KEY; end
        else begin in_valid = 1'b0; in_data = rnd128(); in_key = rnd128(); end
      end
      if (willOut) nOut++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    nTests++; if (nAcc !== 2 || nOut !== 2) begin nFail++; $display("FAIL b2b_counts: accepts %0d outputs %0d want 2 2", nAcc, nOut); end
    nTests++; if (accCyc[1] - accCyc[0] !== 12) begin nFail++; $display("FAIL b2b_spacing: got %0d want 12", accCyc[1] - accCyc[0]); end
    nTests++; if (outs[0] !== Z_CT) begin nFail++; $display("FAIL b2b_zero: got %h want %h", outs[0], Z_CT); end
    nTests++; if (outs[1] !== C1_CT) begin nFail++; $display("FAIL b2b_c1: got %h want %h", outs[1], C1_CT); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] res; int lat; bit to; bit seen;
    int w;
    w = 0;
    while (!in_ready && w < 30) begin @(posedge clk); #1; w++; end
    in_valid = 1'b1; in_data = C1_PT; in_key = C1_KEY;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    nTests++; if (dut.rnd !== 4'd5 || busy !== 1'b1) begin nFail++; $display("FAIL mid_pre: rnd %0d busy %b want 5 1", dut.rnd, busy); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    nTests++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 128'h0) begin
      nFail++;
      $display("FAIL mid_reset: busy %b out_valid %b in_ready %b data %h want 0 0 0 0", busy, out_valid, in_ready, out_data);
    end
    rst_n = 1'b1;
    #1;
    nTests++; if (in_ready !== 1'b1) begin nFail++; $display("FAIL mid_release_in_ready: got %b want 1", in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen = 1'b1;
    end
    nTests++; if (seen) begin nFail++; $display("FAIL mid_no_pulse: out_valid/busy %b want 0", seen); end
    runBlock(C1_PT, C1_KEY, res, lat, to);
    nTests++; if (res !== C1_CT || lat !== 10 || to) begin nFail++; $display("FAIL mid_followup: got %h lat %0d want %h lat 10", res, lat, C1_CT); end
    releaseOut();
  endtask

  task automatic test_random();
    logic [127:0] pt, key, exp, res; int lat; bit to;
    for (int n = 0; n < 10; n++) begin
      pt = rnd128(); key = rnd128();
      if (n == 0) key = '1;
      exp = aesRef(pt, key);
      runBlock(pt, key, res, lat, to);
      nTests++;
      if (res !== exp || lat !== 10 || to) begin
        nFail++;
        $display("FAIL rand%0d: got %h lat %0d want %h lat 10", n, res, lat, exp);
      end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      nTests++; if (out_data !== exp || out_valid !== 1'b1) begin nFail++; $display("FAIL rand%0d_stall: got %h valid %b want %h 1", n, out_data, out_valid, exp); end
      releaseOut();
    end
  endtask

  initial begin
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbT[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b0;
    test_reset();
    test_fips_c1();
    test_app_b();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/aes128_iter_ctrl.md
# aes128_iter_ctrl

Iterative AES-128 encryption controller. It sequences a single shared round datapath (SubBytes → ShiftRows → MixColumns → AddRoundKey) over 10 rounds, expanding round keys on the fly instead of unrolling the full key schedule. It sits between a streaming plaintext/key producer and a ciphertext consumer, with valid/ready handshakes on both sides. It trades throughput for area against the fully combinational encryptor.

## Interface
- Parameters: none. AES-128 only; Nr = 10 is fixed.
- Reset is synchronous and active-low.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `in_valid` input, 1 bit: plaintext/key pair offered.
- `in_ready` output, 1 bit: controller can accept a block.
- `in_data` input, 128 bits: plaintext, FIPS-197 byte order (byte 0 = [127:120], column 0 = [127:96]).
- `in_key` input, 128 bits: cipher key, same byte order.
- `out_valid` output, 1 bit: ciphertext available.
- `out_ready` input, 1 bit: consumer accepts ciphertext.
- `out_data` output, 128 bits: ciphertext, same byte order.
- `busy` output, 1 bit: high in ROUND and DONE.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - ROUND: rounds 1..10.
  - DONE: `out_valid`=1.
- IDLE → ROUND when `in_valid && in_ready`. At that edge:
  - `st <= in_data ^ in_key` (round 0).
  - `rk <= in_key`.
  - `rnd <= 1`.
- ROUND, each cycle:
  - `rk_n = expand(rk, rcon[rnd])`.
  - `w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}`.
  - `w1' = w1 ^ w0'`, `w2' = w2 ^ w1'`, `w3' = w3 ^ w2'`.
  - `rcon` sequence for `rnd` 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- ROUND datapath:
  - `rnd` 1..9: `st <= MixColumns(ShiftRows(SubBytes(st))) ^ rk_n`.
  - `rnd` = 10: `st <= ShiftRows(SubBytes(st)) ^ rk_n`, with MixColumns bypassed.
  - Both cases: `rk <= rk_n`, `rnd <= rnd+1`.
- ROUND → DONE at the edge that completes `rnd`=10. `out_data` is driven from `st` and is stable for the whole of DONE.
- DONE → IDLE when `out_ready`=1; `out_valid` drops at that edge.
- Input handshake:
  - `in_data`/`in_key` are sampled only at the accepting edge and may change freely afterwards.
  - `in_valid` is ignored outside IDLE.
- `rnd` is 4 bits, range 0..10. Values 11..15 are unreachable; if reached, the FSM returns to IDLE.
- Output backpressure: DONE holds indefinitely while `out_ready`=0, with no loss and no change of `out_data`.
- No input is accepted in DONE, including on the cycle where `out_ready`=1. The next accept is possible at the earliest one cycle later, in IDLE.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - FSM = IDLE.
  - `st`, `rk`, `rnd`, `out_data` = 0.
  - `out_valid` = 0, `busy` = 0.
  - `in_ready` = 0 while `rst_n` is low; `in_ready` = `(fsm==IDLE) && rst_n`.
- Reset mid-operation (ROUND or DONE): the in-flight block is discarded. After the edge, all outputs take their reset values. No `out_valid` pulse is produced for the discarded block.
- Latency: if the input handshake occurs at edge E, `out_valid` is high after edge E+10 (10 ROUND cycles).
- Throughput with `out_ready` tied high:
  - DONE lasts 1 cycle, IDLE lasts 1 cycle.
  - One block per 12 cycles: accepts at E, E+12, E+24, …
- `in_valid` and `out_ready` arriving in the same cycle: only the handshake legal in the current state takes effect.
- Critical path: one S-box layer + MixColumns + XOR, in parallel with the key path SubWord + 4 chained XORs.

## Test plan
- FIPS-197 C.1: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f → `out_data` 69c4e0d86a7b0430d8cdb78070b4c55a, `out_valid` rising exactly 10 edges after accept.
- FIPS-197 App. B: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c → 3925841d02dc09fbdc118597196a0b32. Internal `rk` after round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Backpressure and input isolation:
  - Stimulus: hold `out_ready`=0 for 20 cycles after `out_valid`.
  - Required: `out_data` is stable, `in_ready`=0, and `in_valid` pulses are ignored throughout.
  - Release: with `out_ready`=1, `out_valid` falls and `in_ready`=1 on the next cycle.
- Back-to-back with `out_ready`=1:
  - Stimulus: all-zero pt/key, then C.1.
  - Required: outputs 66e94bd4ef8a2c3b884cfa59ca342b2e then 69c4e0d86a7b0430d8cdb78070b4c55a, accepts 12 cycles apart.
  - Also: change `in_data` during ROUND; the result must be unaffected.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 at ROUND `rnd`=5 for one cycle.
  - Required: `busy`=0, `out_valid` never pulses, and `in_ready`=1 the cycle after release.
  - Follow-up: a new C.1 block then encrypts correctly.
